mux8_rr_arbiter: RTL and testbench

Round-robin arbiter that shares the structural 8:1 mux (mux8x1) between eight requesters. It drives the mux select lines S2..S0 and a one-hot grant vector. A requester holds the mux for as long as it keeps its request high. A hold-limit counter forces rotation when other requesters are waiting. The block sits directly in front of mux8x1: sel[2]->S2, sel[1]->S1, sel[0]->S0.

---
 rtl/mux_arb_pkg.sv | 22 ++
 rtl/rr_pick8.sv | 31 +++
 rtl/mux8_rr_arbiter.sv | 127 ++++++++++++
 tb/tb_mux8_rr_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared constants, FSM encoding and vector helpers for the 8-way
// round-robin arbiter that fronts the mux8x1 select lines.
package mux_arb_pkg;

    localparam int unsigned N_REQ = 8;
    localparam int unsigned SEL_W = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
        return 8'd1 << idx;
    endfunction

    function automatic logic [N_REQ-1:0] mask_one(input logic [N_REQ-1:0] vec,
                                                  input logic [SEL_W-1:0] idx);
        return vec & ~onehot8(idx);
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating priority picker: first set bit of req at or
// after ptr, wrapping modulo 8.
module rr_pick8
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             found
);

    logic [SEL_W-1:0] cand_s;

    // Scan farthest offset first so the nearest requester wins last.
    always_comb begin
        idx    = ptr;
        found  = 1'b0;
        cand_s = 3'd0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand_s = ptr + 3'(i);
            if (req[cand_s]) begin
                idx   = cand_s;
                found = 1'b1;
            end else begin
                idx   = idx;
                found = found;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter driving the mux8x1 selects {S2,S1,S0} and a one-hot
// grant; a hold limit forces rotation while other requesters wait.
module mux8_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       gnt_valid
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    arb_state_e state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [7:0] gnt_q, gnt_d;
    logic       gnt_valid_q, gnt_valid_d;

    logic [7:0] others_s;
    logic [7:0] pick_req_s;
    logic [2:0] pick_ptr_s;
    logic [2:0] pick_idx_s;
    logic       pick_found_s;
    logic       release_s;

    // sel_q doubles as the current owner; it also holds the mux steady in IDLE.
    always_comb begin
        others_s  = mask_one(req, sel_q);
        release_s = !req[sel_q] || ((hold_cnt_q == HOLD_LAST) && (others_s != 8'd0));
        if (state_q == GRANT) begin
            pick_req_s = others_s;
            pick_ptr_s = sel_q + 3'd1;
        end else begin
            pick_req_s = req;
            pick_ptr_s = ptr_q;
        end
    end

    rr_pick8 u_pick (
        .req   (pick_req_s),
        .ptr   (pick_ptr_s),
        .idx   (pick_idx_s),
        .found (pick_found_s)
    );

    // Next-state, hold counter and grant decode.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        case (state_q)
            IDLE: begin
                if (pick_found_s) begin
                    state_d     = GRANT;
                    sel_d       = pick_idx_s;
                    gnt_d       = onehot8(pick_idx_s);
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = 8'd0;
                end else begin
                    gnt_d       = 8'd0;
                    gnt_valid_d = 1'b0;
                end
            end
            GRANT: begin
                if (release_s) begin
                    ptr_d = sel_q + 3'd1;
                    if (pick_found_s) begin
                        sel_d       = pick_idx_s;
                        gnt_d       = onehot8(pick_idx_s);
                        gnt_valid_d = 1'b1;
                        hold_cnt_d  = 8'd0;
                    end else begin
                        state_d     = IDLE;
                        gnt_d       = 8'd0;
                        gnt_valid_d = 1'b0;
                        hold_cnt_d  = 8'd0;
                    end
                end else if (others_s == 8'd0) begin
                    hold_cnt_d = 8'd0;
                end else if (hold_cnt_q != HOLD_LAST) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end else begin
                    hold_cnt_d = hold_cnt_q;
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = 8'd0;
                gnt_valid_d = 1'b0;
                hold_cnt_d  = 8'd0;
            end
        endcase
    end

    // State and output registers; rst drops any grant at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= 3'd0;
            ptr_q       <= 3'd0;
            hold_cnt_q  <= 8'd0;
            gnt_q       <= 8'd0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign gnt       = gnt_q;
    assign sel       = sel_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Bench for mux8_rr_arbiter: two instances (MAX_HOLD 4 and 1) share req/rst
// and are checked every cycle against an arithmetic model plus literals.
module tb_mux8_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt4, gnt1;
    logic [2:0] sel4, sel1;
    logic       v4, v1;

    always #5 clk = ~clk;

    mux8_rr_arbiter #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt4), .sel(sel4), .gnt_valid(v4)
    );
    mux8_rr_arbiter #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt1), .sel(sel1), .gnt_valid(v1)
    );

    // mux8x1 data inputs I0..I7 = 0,1,0,1,... behind the MAX_HOLD=1 arbiter
    logic [7:0] ivec = 8'b1010_1010;
    logic       y1;
    assign y1 = ivec[sel1];

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    int m_busy  [2];
    int m_owner [2];
    int m_ptr   [2];
    int m_hold  [2];
    int lim     [2] = '{4, 1};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int pick_m(input logic [7:0] v, input int start);
        for (int o = 0; o < 8; o++) begin
            if (v[(start + o) % 8]) return (start + o) % 8;
        end
        return -1;
    endfunction

    function automatic logic [7:0] others_m(input logic [7:0] v, input int k);
        logic [7:0] r;
        r    = v;
        r[k] = 1'b0;
        return r;
    endfunction

    // Reference model: who owns the mux, from the rotation rules directly.
    always @(posedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (rst) begin
                m_busy[u]  <= 0;
                m_owner[u] <= 0;
                m_ptr[u]   <= 0;
                m_hold[u]  <= 0;
            end else if (m_busy[u] == 0) begin
                if (pick_m(req, m_ptr[u]) >= 0) begin
                    m_busy[u]  <= 1;
                    m_owner[u] <= pick_m(req, m_ptr[u]);
                    m_hold[u]  <= 0;
                end
            end else if (!req[m_owner[u]] ||
                         (m_hold[u] + 1 >= lim[u] && others_m(req, m_owner[u]) != 8'd0)) begin
                m_ptr[u] <= (m_owner[u] + 1) % 8;
                if (pick_m(others_m(req, m_owner[u]), (m_owner[u] + 1) % 8) >= 0) begin
                    m_owner[u] <= pick_m(others_m(req, m_owner[u]), (m_owner[u] + 1) % 8);
                    m_hold[u]  <= 0;
                end else begin
                    m_busy[u] <= 0;
                end
            end else if (others_m(req, m_owner[u]) == 8'd0) begin
                m_hold[u] <= 0;
            end else begin
                m_hold[u] <= m_hold[u] + 1;
            end
        end
    end

    task automatic cmp_unit(input int u, input logic [7:0] g, input logic [2:0] s, input logic v);
        logic [7:0] ge;
        logic [2:0] se;
        ge = (m_busy[u] != 0) ? (8'd1 << m_owner[u]) : 8'd0;
        se = 3'(m_owner[u]);
        check($sformatf("model_gnt_u%0d", u), g, ge);
        check($sformatf("model_sel_u%0d", u), s, se);
        check($sformatf("model_valid_u%0d", u), v, (m_busy[u] != 0));
        check($sformatf("onehot0_u%0d", u), $onehot0(g), 1);
        check($sformatf("valid_eq_or_u%0d", u), v, |g);
        if (v) check($sformatf("sel_matches_gnt_u%0d", u), g, 8'd1 << s);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_unit(0, gnt4, sel4, v4);
            cmp_unit(1, gnt1, sel1, v1);
            check("mux_y_eq_i_sel", y1, ivec[m_owner[1] % 8]);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 8'h00;
        tick();
        rst = 1'b0;
    endtask

    logic [7:0] walk [10] = '{8'h11, 8'h13, 8'h02, 8'h00, 8'hC0, 8'h80, 8'h7F, 8'h00, 8'h55, 8'hAA};

    initial begin
        rst = 1'b1;
        req = 8'h00;
        tick();
        chk_en = 1'b1;
        check("rst_gnt", gnt4, 8'h00);
        check("rst_sel", sel4, 3'd0);
        check("rst_valid", v4, 1'b0);
        rst = 1'b0;

        // single requester, then release to idle
        req = 8'b0000_0100;
        tick();
        check("t1_gnt", gnt4, 8'h04);
        check("t1_sel", sel4, 3'd2);
        check("t1_valid", v4, 1'b1);
        req = 8'h00;
        tick();
        check("t1_idle_gnt", gnt4, 8'h00);
        check("t1_idle_valid", v4, 1'b0);
        check("t1_idle_sel", sel4, 3'd2);

        // full contention: 4-cycle slots on dut4, per-cycle rotation on dut1
        do_reset();
        req = 8'hFF;
        for (int c = 0; c < 36; c++) begin
            tick();
            check("t2_sel4", sel4, (c / 4) % 8);
            check("t2_valid4", v4, 1'b1);
            check("t2_sel1", sel1, c % 8);
            check("t6_y", y1, c % 2);
        end

        // lone holder never forced off; contention starts the hold count
        do_reset();
        req = 8'h20;
        for (int c = 0; c < 10; c++) begin
            tick();
            check("t3_lone_gnt", gnt4, 8'h20);
        end
        req = 8'h24;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("t3_hold_gnt", gnt4, 8'h20);
        end
        tick();
        check("t3_forced_gnt", gnt4, 8'h04);
        check("t3_ptr", dut4.ptr_q, 3'd6);

        // owner 6 drops, search from 7 wraps to 1
        do_reset();
        req = 8'h40;
        tick();
        check("t4_own6", gnt4, 8'h40);
        req = 8'h0A;
        tick();
        check("t4_gnt", gnt4, 8'h02);
        check("t4_sel", sel4, 3'd1);
        check("t4_gnt_u1", gnt1, 8'h02);

        // reset mid-grant
        do_reset();
        req = 8'h08;
        tick();
        check("t5_gnt3", gnt4, 8'h08);
        rst = 1'b1;
        tick();
        check("t5_rst_gnt", gnt4, 8'h00);
        check("t5_rst_sel", sel4, 3'd0);
        check("t5_rst_valid", v4, 1'b0);
        rst = 1'b0;
        req = 8'h81;
        tick();
        check("t5_after_gnt", gnt4, 8'h01);

        // mixed request patterns, checked by the model only
        for (int w = 0; w < 10; w++) begin
            req = walk[w];
            for (int c = 0; c < 3; c++) tick();
        end

        req = 8'h00;
        tick();
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
